// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, ALU opcode encoding and the reservation-station
// entry layout used by alu_rs and its testbench.
package alu_rs_pkg;

  localparam int OP_W   = 6;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;

  // Shared opcode encoding (ALU class). The RS never decodes these; they are
  // carried through to the ALU untouched.
  localparam logic [OP_W-1:0] OP_ADD  = 6'h00;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h01;
  localparam logic [OP_W-1:0] OP_AND  = 6'h02;
  localparam logic [OP_W-1:0] OP_OR   = 6'h03;
  localparam logic [OP_W-1:0] OP_XOR  = 6'h04;
  localparam logic [OP_W-1:0] OP_SLL  = 6'h05;
  localparam logic [OP_W-1:0] OP_SRL  = 6'h06;
  localparam logic [OP_W-1:0] OP_SRA  = 6'h07;
  localparam logic [OP_W-1:0] OP_SLT  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTU = 6'h09;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  q1;
    logic [TAG_W-1:0]  q2;
    logic              q1_busy;
    logic              q2_busy;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  dest;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: decode-issue, CDB, flush and ALU-dispatch signals of the ALU
// reservation station.
//   slave  : the reservation station (consumes issue/CDB/flush, drives
//            is_full_to_dec and the *_to_alu dispatch bundle)
//   master : the surrounding pipeline (decoder, CDB, ROB, ALU)
interface alu_rs_if;
  import alu_rs_pkg::*;

  // issue stage
  logic              is_issue_from_dec;
  logic [OP_W-1:0]   op_from_dec;
  logic [DATA_W-1:0] v1_from_dec;
  logic [DATA_W-1:0] v2_from_dec;
  logic              q1_busy_from_dec;
  logic              q2_busy_from_dec;
  logic [TAG_W-1:0]  q1_from_dec;
  logic [TAG_W-1:0]  q2_from_dec;
  logic [DATA_W-1:0] imm_from_dec;
  logic [PC_W-1:0]   pc_from_dec;
  logic [TAG_W-1:0]  dest_from_dec;
  logic              is_full_to_dec;
  // common data bus / ROB
  logic              is_cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              is_flush_from_rob;
  // dispatch to ALU
  logic [OP_W-1:0]   op_to_alu;
  logic [DATA_W-1:0] v1_to_alu;
  logic [DATA_W-1:0] v2_to_alu;
  logic [DATA_W-1:0] imm_to_alu;
  logic [PC_W-1:0]   pc_to_alu;
  logic [TAG_W-1:0]  dest_to_alu;
  logic              is_empty_to_alu;

  modport slave (
    input  is_issue_from_dec, op_from_dec, v1_from_dec, v2_from_dec,
           q1_busy_from_dec, q2_busy_from_dec, q1_from_dec, q2_from_dec,
           imm_from_dec, pc_from_dec, dest_from_dec,
           is_cdb_valid, cdb_tag, cdb_data, is_flush_from_rob,
    output is_full_to_dec, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu,
           pc_to_alu, dest_to_alu, is_empty_to_alu
  );

  modport master (
    output is_issue_from_dec, op_from_dec, v1_from_dec, v2_from_dec,
           q1_busy_from_dec, q2_busy_from_dec, q1_from_dec, q2_from_dec,
           imm_from_dec, pc_from_dec, dest_from_dec,
           is_cdb_valid, cdb_tag, cdb_data, is_flush_from_rob,
    input  is_full_to_dec, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu,
           pc_to_alu, dest_to_alu, is_empty_to_alu
  );
endinterface

// File: rtl/alu_rs_select.sv
// rs_select: picks one ready reservation-station entry per cycle.
//   i_ready : per-entry ready vector
//   i_age   : per-entry age rank, 0 = oldest (only with RS_AGE_ORDER_EN)
//   o_found : at least one entry is ready
//   o_idx   : chosen entry
// Macro RS_AGE_ORDER_EN: defined -> oldest ready entry wins;
// undefined -> lowest-index ready entry wins.
module rs_select
  import alu_rs_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]            i_ready,
`ifdef RS_AGE_ORDER_EN
  input  logic [N-1:0][IDX_W-1:0] i_age,
`endif
  output logic                    o_found,
  output logic [IDX_W-1:0]        o_idx
);

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] w_best_age;

  // Ranks of busy entries are unique, so a strict compare never ties.
  always_comb begin
    o_found    = 1'b0;
    o_idx      = '0;
    w_best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (i_ready[i] && (!o_found || (i_age[i] < w_best_age))) begin
        o_found    = 1'b1;
        o_idx      = IDX_W'(i);
        w_best_age = i_age[i];
      end
    end
  end
`else
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_ready[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU. Holds issued
// ALU instructions until both operands are present (captured from the CDB,
// including a same-cycle bypass at issue) and dispatches at most one ready
// instruction per cycle onto registered *_to_alu outputs.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_rs_if.slave (issue in, full out, CDB, flush, ALU out)
// Macro RS_AGE_ORDER_EN: defined -> per-entry age ranks, oldest ready
// entry dispatches first; undefined -> lowest-index ready entry first.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_rs_if.slave  bus
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t          r_ent [RS_SIZE];
  logic [OP_W-1:0]    r_op;
  logic [DATA_W-1:0]  r_v1, r_v2, r_imm;
  logic [PC_W-1:0]    r_pc;
  logic [TAG_W-1:0]   r_dest;
  logic               r_empty;

  logic [RS_SIZE-1:0] w_busy, w_ready;
  logic               w_full, w_issue, w_found;
  logic [IDX_W-1:0]   w_sel, w_free;
  logic               w_hit1, w_hit2;
  rs_entry_t          w_new;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && !r_ent[i].q1_busy && !r_ent[i].q2_busy;
    end
  end

  // Full looks only at current busy bits: a slot vacated by this cycle's
  // dispatch is not offered to the issue stage until next cycle.
  assign w_full  = &w_busy;
  assign w_issue = bus.is_issue_from_dec && !w_full;

  // lowest-index free slot
  always_comb begin
    w_free = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!w_busy[i]) w_free = IDX_W'(i);
  end

  // New entry, with operands captured straight off the CDB when the tag
  // being broadcast this cycle is the one the instruction waits on.
  always_comb begin
    w_hit1        = bus.is_cdb_valid && bus.q1_busy_from_dec && (bus.q1_from_dec == bus.cdb_tag);
    w_hit2        = bus.is_cdb_valid && bus.q2_busy_from_dec && (bus.q2_from_dec == bus.cdb_tag);
    w_new         = '0;
    w_new.busy    = 1'b1;
    w_new.op      = bus.op_from_dec;
    w_new.v1      = w_hit1 ? bus.cdb_data : bus.v1_from_dec;
    w_new.v2      = w_hit2 ? bus.cdb_data : bus.v2_from_dec;
    w_new.q1      = bus.q1_from_dec;
    w_new.q2      = bus.q2_from_dec;
    w_new.q1_busy = bus.q1_busy_from_dec && !w_hit1;
    w_new.q2_busy = bus.q2_busy_from_dec && !w_hit2;
    w_new.imm     = bus.imm_from_dec;
    w_new.pc      = bus.pc_from_dec;
    w_new.dest    = bus.dest_from_dec;
  end

`ifdef RS_AGE_ORDER_EN
  // Rank = number of older busy entries; busy ranks are always 0..cnt-1.
  logic [RS_SIZE-1:0][IDX_W-1:0] r_age;
  logic [IDX_W:0]                w_cnt;
  logic [IDX_W-1:0]              w_new_age;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++)
      w_cnt = w_cnt + (IDX_W+1)'(w_busy[i]);
    // issue is only accepted when not full, so this fits in IDX_W bits
    w_new_age = IDX_W'(w_cnt - (IDX_W+1)'(w_found));
  end

  always_ff @(posedge clk) begin
    if (rst || bus.is_flush_from_rob) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++)
        if (w_found && (r_age[i] > r_age[w_sel]))
          r_age[i] <= r_age[i] - IDX_W'(1);
      if (w_issue) r_age[w_free] <= w_new_age;
    end
  end

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_sel (
    .i_ready (w_ready),
    .i_age   (r_age),
    .o_found (w_found),
    .o_idx   (w_sel)
  );
`else
  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_sel (
    .i_ready (w_ready),
    .o_found (w_found),
    .o_idx   (w_sel)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      r_empty <= 1'b1;
      r_op    <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_dest  <= '0;
    end else if (bus.is_flush_from_rob) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      // wakeup; the issuing slot is not busy so this never overlaps issue
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_ent[i].busy && bus.is_cdb_valid) begin
          if (r_ent[i].q1_busy && (r_ent[i].q1 == bus.cdb_tag)) begin
            r_ent[i].v1      <= bus.cdb_data;
            r_ent[i].q1_busy <= 1'b0;
          end
          if (r_ent[i].q2_busy && (r_ent[i].q2 == bus.cdb_tag)) begin
            r_ent[i].v2      <= bus.cdb_data;
            r_ent[i].q2_busy <= 1'b0;
          end
        end
      end
      // dispatch; data outputs hold when nothing is ready
      r_empty <= !w_found;
      if (w_found) begin
        r_ent[w_sel].busy <= 1'b0;
        r_op   <= r_ent[w_sel].op;
        r_v1   <= r_ent[w_sel].v1;
        r_v2   <= r_ent[w_sel].v2;
        r_imm  <= r_ent[w_sel].imm;
        r_pc   <= r_ent[w_sel].pc;
        r_dest <= r_ent[w_sel].dest;
      end
      if (w_issue) r_ent[w_free] <= w_new;
    end
  end

  assign bus.is_full_to_dec  = w_full;
  assign bus.is_empty_to_alu = r_empty;
  assign bus.op_to_alu       = r_op;
  assign bus.v1_to_alu       = r_v1;
  assign bus.v2_to_alu       = r_v2;
  assign bus.imm_to_alu      = r_imm;
  assign bus.pc_to_alu       = r_pc;
  assign bus.dest_to_alu     = r_dest;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs. A slot-level reference model
// (issue-order list for age mode) predicts each dispatch and the cycle it
// appears; a negedge monitor pops and compares whenever the DUT dispatches.
// Honours RS_AGE_ORDER_EN the same way as the design.
`timescale 1ns/1ps
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rs_if bus();
  alu_rs #(.RS_SIZE(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic              busy;
    logic              w1, w2;      // still waiting on q1 / q2
    logic [TAG_W-1:0]  q1, q2, dest;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1, v2, imm;
    logic [PC_W-1:0]   pc;
  } slot_t;

  typedef struct {
    int                cyc;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1, v2, imm;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  dest;
  } exp_t;

  slot_t m [N];
  int    order [$];
  exp_t  expq [$];
  int    cyc    = 0;
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic bit m_ready(input int i);
    return m[i].busy && !m[i].w1 && !m[i].w2;
  endfunction

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < N; i++) if (!m[i].busy) f = 1'b0;
    return f;
  endfunction

  // Reference model: one call per rising edge, using the inputs the DUT sees.
  task automatic step();
    int   sel, fr;
    bit   full, h1, h2;
    exp_t e;
    cyc++;
    if (rst || bus.is_flush_from_rob) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      order.delete();
      return;
    end
    full = m_full();
    sel  = -1;
`ifdef RS_AGE_ORDER_EN
    foreach (order[k]) if (sel < 0 && m_ready(order[k])) sel = order[k];
`else
    for (int i = 0; i < N; i++) if (sel < 0 && m_ready(i)) sel = i;
`endif
    fr = -1;
    for (int i = 0; i < N; i++) if (fr < 0 && !m[i].busy) fr = i;
    if (sel >= 0) begin
      e.cyc = cyc; e.op = m[sel].op; e.v1 = m[sel].v1; e.v2 = m[sel].v2;
      e.imm = m[sel].imm; e.pc = m[sel].pc; e.dest = m[sel].dest;
      expq.push_back(e);
    end
    if (bus.is_cdb_valid) begin
      for (int i = 0; i < N; i++) begin
        if (m[i].busy && m[i].w1 && m[i].q1 == bus.cdb_tag) begin m[i].v1 = bus.cdb_data; m[i].w1 = 1'b0; end
        if (m[i].busy && m[i].w2 && m[i].q2 == bus.cdb_tag) begin m[i].v2 = bus.cdb_data; m[i].w2 = 1'b0; end
      end
    end
    if (sel >= 0) begin
      m[sel].busy = 1'b0;
      for (int k = 0; k < order.size(); k++)
        if (order[k] == sel) begin order.delete(k); break; end
    end
    if (bus.is_issue_from_dec && !full) begin
      h1 = bus.is_cdb_valid && bus.q1_busy_from_dec && bus.q1_from_dec == bus.cdb_tag;
      h2 = bus.is_cdb_valid && bus.q2_busy_from_dec && bus.q2_from_dec == bus.cdb_tag;
      m[fr].busy = 1'b1;
      m[fr].op   = bus.op_from_dec;
      m[fr].w1   = bus.q1_busy_from_dec && !h1;
      m[fr].w2   = bus.q2_busy_from_dec && !h2;
      m[fr].v1   = h1 ? bus.cdb_data : bus.v1_from_dec;
      m[fr].v2   = h2 ? bus.cdb_data : bus.v2_from_dec;
      m[fr].q1   = bus.q1_from_dec;
      m[fr].q2   = bus.q2_from_dec;
      m[fr].imm  = bus.imm_from_dec;
      m[fr].pc   = bus.pc_from_dec;
      m[fr].dest = bus.dest_from_dec;
      order.push_back(fr);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      chk("full", 64'(bus.is_full_to_dec), 64'(m_full()));
      if (bus.is_empty_to_alu === 1'b0) begin
        if (expq.size() == 0) begin
          n_chk++;
          $display("FAIL extra_dispatch: got dispatch dest=%0h, expected none (cycle %0d)", bus.dest_to_alu, cyc);
        end else begin
          e = expq.pop_front();
          chk("disp_cyc",  64'(cyc),             64'(e.cyc));
          chk("disp_op",   64'(bus.op_to_alu),   64'(e.op));
          chk("disp_v1",   64'(bus.v1_to_alu),   64'(e.v1));
          chk("disp_v2",   64'(bus.v2_to_alu),   64'(e.v2));
          chk("disp_imm",  64'(bus.imm_to_alu),  64'(e.imm));
          chk("disp_pc",   64'(bus.pc_to_alu),   64'(e.pc));
          chk("disp_dest", 64'(bus.dest_to_alu), 64'(e.dest));
        end
      end
    end
  end

  task automatic idle_in();
    bus.is_issue_from_dec = 1'b0; bus.op_from_dec = '0;
    bus.v1_from_dec = '0; bus.v2_from_dec = '0;
    bus.q1_busy_from_dec = 1'b0; bus.q2_busy_from_dec = 1'b0;
    bus.q1_from_dec = '0; bus.q2_from_dec = '0;
    bus.imm_from_dec = '0; bus.pc_from_dec = '0; bus.dest_from_dec = '0;
    bus.is_cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.is_flush_from_rob = 1'b0;
  endtask

  task automatic set_issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1, v2,
                           input logic b1, input logic [TAG_W-1:0] q1,
                           input logic b2, input logic [TAG_W-1:0] q2,
                           input logic [DATA_W-1:0] imm, input logic [PC_W-1:0] pc,
                           input logic [TAG_W-1:0] dest);
    bus.is_issue_from_dec = 1'b1; bus.op_from_dec = op;
    bus.v1_from_dec = v1; bus.v2_from_dec = v2;
    bus.q1_busy_from_dec = b1; bus.q1_from_dec = q1;
    bus.q2_busy_from_dec = b2; bus.q2_from_dec = q2;
    bus.imm_from_dec = imm; bus.pc_from_dec = pc; bus.dest_from_dec = dest;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    bus.is_cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m[i].busy = 1'b0;
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_empty", 64'(bus.is_empty_to_alu), 64'd1);
    chk("rst_full",  64'(bus.is_full_to_dec),  64'd0);
    chk("rst_op",    64'(bus.op_to_alu),   64'd0);
    chk("rst_v1",    64'(bus.v1_to_alu),   64'd0);
    chk("rst_v2",    64'(bus.v2_to_alu),   64'd0);
    chk("rst_imm",   64'(bus.imm_to_alu),  64'd0);
    chk("rst_pc",    64'(bus.pc_to_alu),   64'd0);
    chk("rst_dest",  64'(bus.dest_to_alu), 64'd0);
    tick();

    // ADD, both operands ready: one-cycle issue-to-ALU latency
    set_issue(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h1000, 4'd3);
    tick(); idle_in(); tick();
    chk("add_valid", 64'(bus.is_empty_to_alu), 64'd0);
    chk("add_op",    64'(bus.op_to_alu),   64'(OP_ADD));
    chk("add_v1",    64'(bus.v1_to_alu),   64'd5);
    chk("add_v2",    64'(bus.v2_to_alu),   64'd7);
    chk("add_dest",  64'(bus.dest_to_alu), 64'd3);
    tick();
    chk("add_once",  64'(bus.is_empty_to_alu), 64'd1);

    // SUB waiting on tag 9, woken two cycles later
    set_issue(OP_SUB, 32'd0, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0, 32'h10, 32'h1004, 4'd5);
    tick(); idle_in(); tick();
    set_cdb(4'd9, 32'h100);
    tick(); idle_in();
    chk("sub_wait",  64'(bus.is_empty_to_alu), 64'd1);
    tick();
    chk("sub_valid", 64'(bus.is_empty_to_alu), 64'd0);
    chk("sub_v1",    64'(bus.v1_to_alu), 64'h100);
    chk("sub_v2",    64'(bus.v2_to_alu), 64'd2);
    tick();

    // CDB bypass at issue
    set_issue(OP_AND, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'd0, 32'h1008, 4'd6);
    set_cdb(4'd4, 32'hAB);
    tick(); idle_in(); tick();
    chk("byp_valid", 64'(bus.is_empty_to_alu), 64'd0);
    chk("byp_v2",    64'(bus.v2_to_alu), 64'hAB);
    tick();

    // fill all entries, drop a 9th issue, then drain
    for (int k = 0; k < N; k++) begin
      set_issue(OP_OR, DATA_W'(k), DATA_W'(k + 1), 1'b1, 4'd14, 1'b0, 4'd0,
                DATA_W'(k), PC_W'(32'h2000 + 4 * k), TAG_W'(k));
      tick();
    end
    chk("fill_full", 64'(bus.is_full_to_dec), 64'd1);
    set_issue(OP_XOR, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h3000, 4'd15);
    tick(); idle_in();
    set_cdb(4'd14, 32'h55);
    tick(); idle_in();
    chk("drain_full_hold", 64'(bus.is_full_to_dec), 64'd1);
    tick();
    chk("drain_full_fall", 64'(bus.is_full_to_dec), 64'd0);
    chk("drain_first",     64'(bus.dest_to_alu),    64'd0);
    repeat (N + 1) tick();

    // flush with 3 pending plus a simultaneous ready issue
    for (int k = 0; k < 3; k++) begin
      set_issue(OP_SLL, 32'd1, 32'd2, 1'b1, 4'd10, 1'b0, 4'd0, 32'd0, 32'h4000, TAG_W'(8 + k));
      tick();
    end
    set_issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h4010, 4'd12);
    bus.is_flush_from_rob = 1'b1;
    tick(); idle_in();
    chk("flush_full",  64'(bus.is_full_to_dec),  64'd0);
    chk("flush_empty", 64'(bus.is_empty_to_alu), 64'd1);
    set_cdb(4'd10, 32'h77);
    tick(); idle_in(); tick();
    chk("flush_nodisp", 64'(bus.is_empty_to_alu), 64'd1);
    set_issue(OP_SRL, 32'd3, 32'd4, 1'b1, 4'd11, 1'b0, 4'd0, 32'd0, 32'h4020, 4'd13);
    tick(); idle_in();
    chk("flush_slot0_busy", 64'(dut.r_ent[0].busy), 64'd1);
    chk("flush_slot0_dest", 64'(dut.r_ent[0].dest), 64'd13);
    set_cdb(4'd11, 32'h99);
    tick(); idle_in(); tick(); tick();

    // randomized traffic, with one mid-stream reset
    for (int c = 0; c < 400; c++) begin
      idle_in();
      if ($urandom_range(0, 99) < 60)
        set_issue(OP_W'($urandom_range(0, 63)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)),
                  $urandom, $urandom, TAG_W'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) < 50)
        set_cdb(TAG_W'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 99) < 2) bus.is_flush_from_rob = 1'b1;
      if (c == 200) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    // broadcast every tag so every pending entry drains
    idle_in();
    for (int t = 0; t < 16; t++) begin
      set_cdb(TAG_W'(t), $urandom);
      tick();
    end
    idle_in();
    repeat (N + 4) tick();
    chk("end_drained", 64'(expq.size()), 64'd0);
    chk("end_empty",   64'(bus.is_empty_to_alu), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
